// File: rtl/pwm_pkg.sv
// Shared constants for the PWM generator/capture pair.
package pwm_pkg;

    localparam int SYS_CLK_HZ    = 50_000_000;
    localparam int CNT_W_DEFAULT = 26;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_MEAS_HIGH = 2'd1;
    localparam logic [1:0] ST_MEAS_LOW  = 2'd2;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchronizer for an asynchronous input, followed by a delay flop
// that yields single-cycle rise/fall strobes on the synchronized level.
module edge_sync #(
    parameter int STAGES = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures period and high time of a PWM input in sys_clk cycles, with a
// loss-of-signal timeout.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no period in progress; waiting for the first rising edge
// ST_MEAS_HIGH | after a rise; counting high time until the falling edge
// ST_MEAS_LOW  | after a fall; next rise closes the period and reports it
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int TIMEOUT_CYC = SYS_CLK_HZ,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             pwm_in,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             no_signal,
    output logic             level
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    logic sync, rise, fall, timeout;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_tmp_q, high_tmp_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             nosig_q, nosig_d;

    edge_sync #(
        .STAGES(SYNC_STAGES)
    ) u_edge_sync (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .async_i  (pwm_in),
        .sync_o   (sync),
        .rise_o   (rise),
        .fall_o   (fall)
    );

    // cnt_q reads N on the cycle N after the last rise, so on a fall or rise
    // cycle it already equals the high time or period of the synchronized signal.
    assign timeout = (cnt_q == TIMEOUT_VAL) && !rise;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        high_tmp_d = high_tmp_q;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        nosig_d    = nosig_q;

        if (rise) begin
            cnt_d = CNT_W'(1);
        end else if (timeout) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            nosig_d = 1'b1;
        end

        if (!timeout) begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) state_d = ST_MEAS_HIGH;
                end
                ST_MEAS_HIGH: begin
                    if (fall) begin
                        high_tmp_d = cnt_q;
                        state_d    = ST_MEAS_LOW;
                    end
                end
                ST_MEAS_LOW: begin
                    if (rise) begin
                        state_d  = ST_MEAS_HIGH;
                        period_d = cnt_q;
                        high_d   = high_tmp_q;
                        valid_d  = 1'b1;
                        nosig_d  = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            high_tmp_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            nosig_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            high_tmp_q <= high_tmp_d;
            period_q   <= period_d;
            high_q     <= high_d;
            valid_q    <= valid_d;
            nosig_q    <= nosig_d;
        end
    end

    assign meas_valid = valid_q;
    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign no_signal  = nosig_q;
    assign level      = sync;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: table of steady waveforms plus hand-written
// timeout, restart and mid-measurement reset sequences.
module tb_pwm_capture;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 1000;

    logic             sys_clk = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic             pwm_in = 1'b0;
    logic             meas_valid;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             no_signal;
    logic             level;

    pwm_capture #(
        .CNT_W      (CNT_W),
        .TIMEOUT_CYC(TIMEOUT),
        .SYNC_STAGES(2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pwm_in    (pwm_in),
        .meas_valid(meas_valid),
        .period_cnt(period_cnt),
        .high_cnt  (high_cnt),
        .no_signal (no_signal),
        .level     (level)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        int period;
        int high;
        bit ns;
        bit ns_before;
        int cyc;
    } pulse_t;

    typedef struct {
        int high;
        int low;
        int n;
        int exp_pulses;
        int exp_period;
        int exp_high;
    } vec_t;

    pulse_t pq[$];
    int     cyc_n = 0;
    bit     ns_prev = 1'b1;
    int     ns_rise_cyc = -1;
    bit     ns_low_seen = 1'b0;
    int     checks = 0;
    int     errors = 0;

    always @(posedge sys_clk) cyc_n++;

    always @(negedge sys_clk) begin
        pulse_t p;
        if (meas_valid) begin
            p.period    = int'(period_cnt);
            p.high      = int'(high_cnt);
            p.ns        = no_signal;
            p.ns_before = ns_prev;
            p.cyc       = cyc_n;
            pq.push_back(p);
        end
        if (no_signal && !ns_prev) ns_rise_cyc = cyc_n;
        if (!no_signal) ns_low_seen = 1'b1;
        ns_prev = no_signal;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic drive(input int h, input int l, input int n);
        repeat (n) begin
            pwm_in = 1'b1;
            cyc(h);
            pwm_in = 1'b0;
            cyc(l);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"},  int'(meas_valid), 0);
        check({tag, "_period"}, int'(period_cnt), 0);
        check({tag, "_high"},   int'(high_cnt),   0);
        check({tag, "_nosig"},  int'(no_signal),  1);
        check({tag, "_level"},  int'(level),      0);
    endtask

    vec_t vecs[7];

    initial begin
        int base;
        int k;
        int spacing;

        vecs[0] = '{high: 25,  low: 25,  n: 4, exp_pulses: 3, exp_period: 50,  exp_high: 25};
        vecs[1] = '{high: 5,   low: 20,  n: 3, exp_pulses: 3, exp_period: 25,  exp_high: 5};
        vecs[2] = '{high: 1,   low: 1,   n: 6, exp_pulses: 6, exp_period: 2,   exp_high: 1};
        vecs[3] = '{high: 3,   low: 7,   n: 4, exp_pulses: 4, exp_period: 10,  exp_high: 3};
        vecs[4] = '{high: 100, low: 100, n: 3, exp_pulses: 3, exp_period: 200, exp_high: 100};
        vecs[5] = '{high: 1,   low: 9,   n: 3, exp_pulses: 3, exp_period: 10,  exp_high: 1};
        vecs[6] = '{high: 9,   low: 1,   n: 3, exp_pulses: 3, exp_period: 10,  exp_high: 9};

        cyc(3);
        check_reset_outputs("reset");
        sys_rst_n = 1'b1;
        cyc(2);

        // Input held low: nothing may be reported through repeated idle timeouts.
        cyc(5000);
        check("idle_pulses", pq.size(), 0);
        check("idle_nosig_low_seen", int'(ns_low_seen), 0);
        check("idle_nosig", int'(no_signal), 1);
        check("idle_period", int'(period_cnt), 0);
        check("idle_high", int'(high_cnt), 0);

        for (int i = 0; i < 7; i++) begin
            base = pq.size();
            drive(vecs[i].high, vecs[i].low, vecs[i].n);
            cyc(4);
            spacing = (pq.size() >= 2) ? pq[pq.size()-1].cyc - pq[pq.size()-2].cyc : -1;
            check($sformatf("row%0d_pulses", i), pq.size() - base, vecs[i].exp_pulses);
            check($sformatf("row%0d_period", i), int'(period_cnt), vecs[i].exp_period);
            check($sformatf("row%0d_high", i), int'(high_cnt), vecs[i].exp_high);
            check($sformatf("row%0d_nosig", i), int'(no_signal), 0);
            check($sformatf("row%0d_spacing", i), spacing, vecs[i].high + vecs[i].low);
            if (i == 0) begin
                check("first_pulse_nosig_before", (pq.size() > 0) ? int'(pq[0].ns_before) : -1, 1);
                check("first_pulse_nosig", (pq.size() > 0) ? int'(pq[0].ns) : -1, 0);
            end
        end

        // Timeout with the input stuck high after a valid 200/100 waveform.
        base = pq.size();
        drive(100, 100, 3);
        pwm_in = 1'b1;
        k = 0;
        while (!no_signal && k < 1500) begin
            cyc(1);
            k++;
        end
        check("timeout_seen", int'(no_signal), 1);
        cyc(1);
        check("timeout_pulses", pq.size() - base, 4);
        check("timeout_delay", (pq.size() > 0) ? ns_rise_cyc - pq[pq.size()-1].cyc : -1, TIMEOUT);
        check("timeout_period_kept", int'(period_cnt), 200);
        check("timeout_high_kept", int'(high_cnt), 100);
        check("timeout_level", int'(level), 1);

        base = pq.size();
        pwm_in = 1'b0;
        cyc(50);
        pwm_in = 1'b1;
        cyc(60);
        pwm_in = 1'b0;
        cyc(90);
        check("restart_one_rise_pulses", pq.size() - base, 0);
        check("restart_one_rise_nosig", int'(no_signal), 1);
        pwm_in = 1'b1;
        cyc(60);
        pwm_in = 1'b0;
        cyc(10);
        check("restart_pulses", pq.size() - base, 1);
        check("restart_period", int'(period_cnt), 150);
        check("restart_high", int'(high_cnt), 60);
        check("restart_nosig", int'(no_signal), 0);

        // Reset in the low phase of a running measurement.
        drive(20, 30, 3);
        pwm_in = 1'b1;
        cyc(20);
        pwm_in = 1'b0;
        cyc(10);
        sys_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        cyc(2);
        sys_rst_n = 1'b1;
        cyc(5);
        base = pq.size();
        drive(20, 30, 3);
        cyc(4);
        check("midrst_pulses", pq.size() - base, 2);
        check("midrst_period", int'(period_cnt), 50);
        check("midrst_high", int'(high_cnt), 20);
        check("midrst_first_nosig_before", (pq.size() > base) ? int'(pq[base].ns_before) : -1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
